rr_arbiter_param: RTL and testbench
===================================

Name: rr_arbiter_param

Overview:
- Parametrised round-robin arbiter, successor to the fixed 8-way one-hot arbiter in the board-selection path.
- Arbitrates N_REQ requesters using a rotating priority pointer.
- Optionally holds a grant across multiple cycles until the owner signals done, drops its request, or hits a fairness timeout.
- Outputs a one-hot grant plus an encoded select; the encoding uses value N_REQ as "invalid", matching the existing board_sel convention.

Parameters:
- N_REQ, 8, number of requesters (>=2).
- SEL_W, $clog2(N_REQ+1), width of the encoded select; must be able to represent N_REQ.
- HOLD_EN, 1, 1 = grant held until release; 0 = new arbitration every enabled cycle.
- MAX_HOLD, 16, maximum consecutive enabled cycles a grant may be held (>=1); ignored when HOLD_EN=0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  advance enable; when low, all state is frozen.
- req  in  N_REQ  request vector, bit i = requester i.
- done  in  1  owner of the current grant releases it this cycle.
- gnt  out  N_REQ  registered one-hot grant, all-zero when idle.
- gnt_valid  out  1  high when gnt != 0.
- gnt_sel  out  SEL_W  index of the granted requester; N_REQ when invalid.
- hold_cnt  out  $clog2(MAX_HOLD+1)  cycles the current grant has been held (debug).

Behaviour:
- **Reset** (rst=1 at a clock edge):
  - gnt=0, gnt_valid=0, gnt_sel=N_REQ, hold_cnt=0.
  - ptr=0, state=IDLE.
  - Takes precedence over everything else, including mid-hold; gnt drops at that edge.
- **Priority pick** (combinational):
  - Winner is the first set bit of the candidate vector, scanning upward from ptr and wrapping modulo N_REQ.
  - Implemented with a masked find-first: bits at or above ptr first, then the unmasked fallback.
- **State IDLE** (gnt=0), enable=1:
  - Any req set: pick winner w; at the next edge gnt=onehot(w), hold_cnt=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
  - req=0: stay IDLE.
- **State GRANT**, enable=1, current owner g:
  - A release happens when any of these hold: done=1, req[g]=0, or (HOLD_EN=1 and hold_cnt==MAX_HOLD-1).
  - HOLD_EN=0: every enabled cycle counts as a release.
  - **On release:**
    - ptr <= (g+1) mod N_REQ.
    - Re-arbitrate in the same cycle using the new ptr and candidate vector req & ~onehot(g).
    - If a winner exists, gnt switches directly to it at the next edge with no idle bubble, hold_cnt=0, state stays GRANT.
    - Otherwise gnt=0 and state=IDLE.
  - **No release:** gnt unchanged, hold_cnt++.
- **Simultaneous events:**
  - done with the owner's req still high: the owner is excluded for that re-arbitration.
  - If the owner is the only requester, gnt goes to 0 for one cycle, then the owner is re-granted from IDLE.
- **Timeout:** identical to done; forces fairness when other requesters are waiting.
- **enable=0:** gnt, ptr, hold_cnt and state hold their values; done and req are ignored.
- **done in IDLE:** ignored.
- **Derived outputs:** gnt_sel and gnt_valid are decoded combinationally from the registered gnt.
- **Invariant:** gnt is always either zero or one-hot.

Decomposition:
- Package arb_pkg holds:
  - state enum {IDLE, GRANT};
  - a function onehot_to_idx(vec, n) that returns n for zero/non-one-hot input;
  - the constant convention that the invalid select equals N_REQ.
- Sub-module rr_priority_pick: combinational, parametrised by N_REQ; inputs cand[N_REQ] and ptr; outputs win_onehot and win_valid.
- The top level contains the FSM, ptr, hold counter and output registers.

Test Plan (N_REQ=4, HOLD_EN=1, MAX_HOLD=4 unless noted):
1. rst=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_sel=4, gnt_valid=0 throughout. After rst falls, gnt=4'b0001 one cycle later.
2. req=4'b1111 held, done pulsed every cycle -> grant rotates 0,1,2,3,0 with no idle cycles between grants.
3. req=4'b0101, never done -> gnt=0001 for 4 cycles (hold_cnt 0..3), then 0100 for 4 cycles, then 0001 again (timeout rotation).
4. Owner 2 alone (req=4'b0100), done=1 -> gnt=0 for one cycle, then 0100 again; ptr=3 after the release.
5. Mid-grant: enable=0 for 3 cycles with done=1 -> gnt and hold_cnt frozen. Then rst=1 during GRANT -> gnt=0 and gnt_sel=4 at that edge.
6. HOLD_EN=0, N_REQ=8, req=8'b10000010 -> gnt alternates 00000010/10000000 every cycle. Across the whole test, gnt is never non-one-hot (assertion).

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter: FSM states, the
// invalid-select convention and a one-hot to index decoder.
package arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Widest request vector the decoder helper accepts.
  localparam int ONEHOT_MAX_W = 64;

  // The encoded select uses the requester count itself as "no grant".
  function automatic int invalid_sel(input int n);
    return n;
  endfunction

  // Returns the index of the single set bit, or n when vec is zero or has
  // more than one bit set within its low n bits.
  function automatic int onehot_to_idx(input logic [ONEHOT_MAX_W-1:0] vec,
                                       input int n);
    int idx;
    int cnt;
    idx = invalid_sel(n);
    cnt = 0;
    for (int i = 0; i < ONEHOT_MAX_W; i++) begin
      if ((i < n) && vec[i]) begin
        cnt = cnt + 1;
        idx = i;
      end
    end
    if (cnt != 1) idx = invalid_sel(n);
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set bit of cand at or above
// ptr, falling back to the first set bit overall when nothing is above ptr.
module rr_priority_pick #(
  parameter int N_REQ = 8,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] cand,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic             win_valid
);

  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] masked_first;
  logic [N_REQ-1:0] cand_first;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mask[i] = (PTR_W'(i) >= ptr);
    end
  end

  assign masked = cand & mask;

  // x & -x isolates the lowest set bit.
  assign masked_first = masked & (~masked + N_REQ'(1));
  assign cand_first   = cand & (~cand + N_REQ'(1));

  assign win_onehot = (masked != '0) ? masked_first : cand_first;
  assign win_valid  = (cand != '0);

endmodule

// File: rtl/rr_arbiter_param.sv
// Parametrised round-robin arbiter with optional grant hold, owner release
// via done or dropped request, and a fairness timeout on long holds.
module rr_arbiter_param
  import arb_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int SEL_W    = $clog2(N_REQ + 1),
  parameter int HOLD_EN  = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [N_REQ-1:0]              req,
  input  logic                          done,
  output logic [N_REQ-1:0]              gnt,
  output logic                          gnt_valid,
  output logic [SEL_W-1:0]              gnt_sel,
  output logic [$clog2(MAX_HOLD+1)-1:0] hold_cnt
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int HC_W  = $clog2(MAX_HOLD + 1);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [HC_W-1:0]  hold_q, hold_d;

  logic             hold_mode;
  logic             owner_req;
  logic             timeout;
  logic             release_now;
  int               owner_idx;
  logic [PTR_W-1:0] ptr_after_owner;
  logic [N_REQ-1:0] pick_cand;
  logic [PTR_W-1:0] pick_ptr;
  logic [N_REQ-1:0] pick_win;
  logic             pick_valid;

  assign hold_mode = (HOLD_EN != 0);
  assign owner_req = |(req & gnt_q);
  assign timeout   = hold_mode && (hold_q == HC_W'(MAX_HOLD - 1));

  // Without hold every enabled grant cycle is a release point.
  assign release_now = !hold_mode || done || !owner_req || timeout;

  assign owner_idx       = onehot_to_idx(ONEHOT_MAX_W'(gnt_q), N_REQ);
  assign ptr_after_owner = (owner_idx >= N_REQ - 1) ? '0 : PTR_W'(owner_idx + 1);

  // In GRANT the picker sees the post-release pointer and excludes the owner,
  // so a handover to a waiting requester happens without an idle cycle.
  assign pick_cand = (state_q == GRANT) ? (req & ~gnt_q) : req;
  assign pick_ptr  = (state_q == GRANT) ? ptr_after_owner : ptr_q;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .cand       (pick_cand),
    .ptr        (pick_ptr),
    .win_onehot (pick_win),
    .win_valid  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_d   = pick_win;
            hold_d  = '0;
            state_d = GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            ptr_d  = ptr_after_owner;
            hold_d = '0;
            if (pick_valid) begin
              gnt_d = pick_win;
            end else begin
              gnt_d   = '0;
              state_d = IDLE;
            end
          end else begin
            hold_d = hold_q + HC_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    gnt       = gnt_q;
    hold_cnt  = hold_q;
    gnt_valid = (gnt_q != '0);
    gnt_sel   = SEL_W'(onehot_to_idx(ONEHOT_MAX_W'(gnt_q), N_REQ));
  end

endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench for rr_arbiter_param: a 4-way holding arbiter and an 8-way
// non-holding one, checked through expected-value queues.
module tb_rr_arbiter_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N_REQ=4, HOLD_EN=1, MAX_HOLD=4
  logic       rst_a, en_a, done_a;
  logic [3:0] req_a, gnt_a;
  logic       gv_a;
  logic [2:0] sel_a, hc_a;

  // Instance B: N_REQ=8, HOLD_EN=0
  logic       rst_b, en_b, done_b;
  logic [7:0] req_b, gnt_b;
  logic       gv_b;
  logic [3:0] sel_b;
  logic [4:0] hc_b;

  logic [6:0]  exp_a_q[$];
  logic [12:0] exp_b_q[$];
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  rr_arbiter_param #(.N_REQ(4), .HOLD_EN(1), .MAX_HOLD(4)) dut_a (
    .clk(clk), .rst(rst_a), .enable(en_a), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_valid(gv_a), .gnt_sel(sel_a), .hold_cnt(hc_a)
  );

  rr_arbiter_param #(.N_REQ(8), .HOLD_EN(0)) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_valid(gv_b), .gnt_sel(sel_b), .hold_cnt(hc_b)
  );

  function automatic int idx_of(input logic [7:0] v, input int n);
    int r;
    r = n;
    for (int i = 0; i < n; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Drive one cycle on A; expected values describe outputs after the next edge.
  task automatic step_a(input logic r, input logic e, input logic [3:0] rq,
                        input logic d, input logic [3:0] eg, input logic [2:0] eh);
    rst_a = r; en_a = e; req_a = rq; done_a = d;
    exp_a_q.push_back({eg, eh});
    @(negedge clk);
  endtask

  task automatic step_b(input logic r, input logic [7:0] rq, input logic [7:0] eg);
    rst_b = r; en_b = 1'b1; req_b = rq; done_b = 1'b0;
    exp_b_q.push_back({eg, 5'd0});
    @(negedge clk);
  endtask

  // Monitor: compares each DUT output one tick after the clock edge.
  initial begin
    logic [6:0]  ea;
    logic [12:0] eb;
    logic [3:0]  ega;
    logic [7:0]  egb;
    logic [2:0]  esa;
    logic [3:0]  esb;
    forever begin
      @(posedge clk);
      #1;
      if (exp_a_q.size() > 0) begin
        ea  = exp_a_q.pop_front();
        ega = ea[6:3];
        esa = 3'(idx_of({4'b0, ega}, 4));
        checks++;
        if (gnt_a !== ega || gv_a !== (|ega) || sel_a !== esa || hc_a !== ea[2:0]) begin
          errors++;
          $display("FAIL arb_a @%0t: gnt=%b valid=%b sel=%0d hold=%0d, expected gnt=%b valid=%b sel=%0d hold=%0d",
                   $time, gnt_a, gv_a, sel_a, hc_a, ega, |ega, esa, ea[2:0]);
        end
      end
      if (exp_b_q.size() > 0) begin
        eb  = exp_b_q.pop_front();
        egb = eb[12:5];
        esb = 4'(idx_of(egb, 8));
        checks++;
        if (gnt_b !== egb || gv_b !== (|egb) || sel_b !== esb || hc_b !== eb[4:0]) begin
          errors++;
          $display("FAIL arb_b @%0t: gnt=%b valid=%b sel=%0d hold=%0d, expected gnt=%b valid=%b sel=%0d hold=%0d",
                   $time, gnt_b, gv_b, sel_b, hc_b, egb, |egb, esb, eb[4:0]);
        end
      end
      if (chk_on) begin
        checks++;
        if (!$onehot0(gnt_a) || !$onehot0(gnt_b)) begin
          errors++;
          $display("FAIL onehot @%0t: gnt_a=%b gnt_b=%b, expected zero or one-hot", $time, gnt_a, gnt_b);
        end
      end
    end
  end

  initial begin
    rst_b = 1'b1; en_b = 1'b1; req_b = '0; done_b = 1'b0;

    // Reset with all requests pending, then first grant one cycle later.
    step_a(1, 1, 4'b1111, 0, 4'b0000, 0);
    step_a(1, 1, 4'b1111, 0, 4'b0000, 0);
    chk_on = 1'b1;
    step_a(0, 1, 4'b1111, 0, 4'b0001, 0);

    // done every cycle: rotation with no idle gap.
    step_a(0, 1, 4'b1111, 1, 4'b0010, 0);
    step_a(0, 1, 4'b1111, 1, 4'b0100, 0);
    step_a(0, 1, 4'b1111, 1, 4'b1000, 0);
    step_a(0, 1, 4'b1111, 1, 4'b0001, 0);

    // Timeout rotation between requesters 0 and 2.
    step_a(0, 1, 4'b0101, 0, 4'b0001, 1);
    step_a(0, 1, 4'b0101, 0, 4'b0001, 2);
    step_a(0, 1, 4'b0101, 0, 4'b0001, 3);
    step_a(0, 1, 4'b0101, 0, 4'b0100, 0);
    step_a(0, 1, 4'b0101, 0, 4'b0100, 1);
    step_a(0, 1, 4'b0101, 0, 4'b0100, 2);
    step_a(0, 1, 4'b0101, 0, 4'b0100, 3);
    step_a(0, 1, 4'b0101, 0, 4'b0001, 0);

    // Owner 0 drops its request; 2 takes over, then releases while alone.
    step_a(0, 1, 4'b0100, 0, 4'b0100, 0);
    step_a(0, 1, 4'b0100, 1, 4'b0000, 0);
    step_a(0, 1, 4'b0100, 0, 4'b0100, 0);
    // ptr is 3 after that release, so requester 3 wins ahead of 0 and 1.
    step_a(0, 1, 4'b1111, 1, 4'b1000, 0);

    // Freeze mid-grant with done asserted, then reset during GRANT.
    step_a(0, 1, 4'b1111, 0, 4'b1000, 1);
    step_a(0, 0, 4'b1111, 1, 4'b1000, 1);
    step_a(0, 0, 4'b1111, 1, 4'b1000, 1);
    step_a(0, 0, 4'b1111, 1, 4'b1000, 1);
    step_a(1, 1, 4'b1111, 0, 4'b0000, 0);
    step_a(0, 0, 4'b1111, 0, 4'b0000, 0);
    step_a(0, 1, 4'b1111, 0, 4'b0001, 0);

    // Drop to idle, done ignored in IDLE, then grant from ptr=1.
    step_a(0, 1, 4'b0000, 0, 4'b0000, 0);
    step_a(0, 1, 4'b0000, 1, 4'b0000, 0);
    step_a(0, 1, 4'b0010, 0, 4'b0010, 0);

    // Non-holding 8-way instance alternates between requesters 1 and 7.
    step_a(0, 1, 4'b0000, 0, 4'b0000, 0);
    step_b(1, 8'b0000_0000, 8'b0000_0000);
    step_b(0, 8'b1000_0010, 8'b0000_0010);
    for (int i = 0; i < 3; i++) begin
      step_b(0, 8'b1000_0010, 8'b1000_0000);
      step_b(0, 8'b1000_0010, 8'b0000_0010);
    end

    @(negedge clk);
    checks++;
    if (exp_a_q.size() != 0 || exp_b_q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending a=%0d b=%0d, expected 0 and 0", exp_a_q.size(), exp_b_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
